clock_phase_monitor: RTL and testbench

- Receiving end of the two-phase clock interface produced by the clock divider.
- Samples the divider's clk1/clk2 outputs as data in the clkIn domain and checks that they are complementary and toggle on every clkIn edge.
- Declares lock after a run of good cycles and tracks which phase is high; it also counts violations and latches a fault on persistent loss.
- Sits beside the divider as a health/phase monitor for the core's two-phase sequencing logic.

---
 rtl/clock_phase_monitor_if.sv | 32 +++
 rtl/clock_phase_monitor.sv | 129 ++++++++++++
 tb/tb_clock_phase_monitor.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/clock_phase_monitor_if.sv
// clock_phase_monitor_if: groups the phase inputs and health/status outputs of
// clock_phase_monitor.
//   phA, phB     divider clk1/clk2, sampled as data by the monitor
//   clearFault   single-cycle request to leave FAULT
//   locked       high only in LOCKED
//   fault        high only in FAULT
//   phase        registered phA sample while LOCKED, else 0
//   errCount     saturating count of bad evaluations seen in LOCKED
//   state        IDLE=0, ACQUIRE=1, LOCKED=2, FAULT=3
// master drives the phases and clearFault; slave is the monitor.
interface clock_phase_monitor_if #(
    parameter int unsigned ERR_W = 8
);
    logic             phA;
    logic             phB;
    logic             clearFault;
    logic             locked;
    logic             fault;
    logic             phase;
    logic [ERR_W-1:0] errCount;
    logic [1:0]       state;

    modport master (
        output phA, phB, clearFault,
        input  locked, fault, phase, errCount, state
    );

    modport slave (
        input  phA, phB, clearFault,
        output locked, fault, phase, errCount, state
    );
endinterface

// File: rtl/clock_phase_monitor.sv
// clock_phase_monitor: samples the divider's two-phase outputs in the clkIn
// domain, checks that they are complementary and toggle every clkIn edge,
// declares lock after LOCK_CYCLES good evaluations, counts violations while
// locked and latches a fault after MAX_MISS consecutive bad evaluations.
//   clkIn  fast reference clock, all logic on posedge
//   reset  synchronous, active-high reset
//   bus    clock_phase_monitor_if.slave (phA, phB, clearFault in;
//          locked, fault, phase, errCount, state out)
module clock_phase_monitor #(
    parameter int unsigned LOCK_CYCLES = 4,
    parameter int unsigned MAX_MISS    = 3,
    parameter int unsigned ERR_W       = 8
) (
    input logic                  clkIn,
    input logic                  reset,
    clock_phase_monitor_if.slave bus
);
    localparam int unsigned GW = $clog2(LOCK_CYCLES + 1);
    localparam int unsigned MW = $clog2(MAX_MISS + 1);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StAcquire = 2'd1,
        StLocked  = 2'd2,
        StFault   = 2'd3
    } state_e;

    state_e           stateQ, stateD;
    logic [1:0]       curQ, curD;     // {a, b} sample
    logic [1:0]       prevQ, prevD;
    logic [1:0]       fillQ, fillD;   // number of valid samples held, 0..2
    logic [GW-1:0]    goodCntQ, goodCntD;
    logic [MW-1:0]    missCntQ, missCntD;
    logic [ERR_W-1:0] errCountQ, errCountD;

    logic valid, good, bad;

    // Evaluation uses the pre-edge samples; needs two of them to see a toggle.
    assign valid = (fillQ == 2'd2);
    assign good  = (curQ[1] != curQ[0]) && (curQ[1] != prevQ[1]);
    assign bad   = valid && !good;

    always_comb begin
        stateD    = stateQ;
        curD      = curQ;
        prevD     = prevQ;
        fillD     = fillQ;
        goodCntD  = goodCntQ;
        missCntD  = missCntQ;
        errCountD = errCountQ;

        // FAULT freezes the sample pipeline so the outputs hold.
        if (stateQ != StFault) begin
            curD  = {bus.phA, bus.phB};
            prevD = curQ;
            fillD = (fillQ == 2'd2) ? 2'd2 : fillQ + 2'd1;
        end

        unique case (stateQ)
            StIdle: begin
                if (fillD == 2'd2) begin
                    stateD = StAcquire;
                end
            end
            StAcquire: begin
                if (valid && good) begin
                    if (goodCntQ == GW'(LOCK_CYCLES - 1)) begin
                        stateD   = StLocked;
                        goodCntD = '0;
                        missCntD = '0;
                    end else begin
                        goodCntD = goodCntQ + GW'(1);
                    end
                end else if (bad) begin
                    goodCntD = '0;
                end
            end
            StLocked: begin
                if (valid && good) begin
                    missCntD = '0;
                end else if (bad) begin
                    if (errCountQ != '1) begin
                        errCountD = errCountQ + ERR_W'(1);
                    end
                    missCntD = missCntQ + MW'(1);
                    if (missCntQ == MW'(MAX_MISS - 1)) begin
                        stateD = StFault;
                    end
                end
            end
            StFault: begin
                if (bus.clearFault) begin
                    stateD   = StIdle;
                    fillD    = 2'd0;
                    goodCntD = '0;
                    missCntD = '0;
                end
            end
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge clkIn) begin
        if (reset) begin
            stateQ    <= StIdle;
            curQ      <= 2'b00;
            prevQ     <= 2'b00;
            fillQ     <= 2'd0;
            goodCntQ  <= '0;
            missCntQ  <= '0;
            errCountQ <= '0;
        end else begin
            stateQ    <= stateD;
            curQ      <= curD;
            prevQ     <= prevD;
            fillQ     <= fillD;
            goodCntQ  <= goodCntD;
            missCntQ  <= missCntD;
            errCountQ <= errCountD;
        end
    end

    // All outputs decode registers only.
    assign bus.locked   = (stateQ == StLocked);
    assign bus.fault    = (stateQ == StFault);
    assign bus.phase    = (stateQ == StLocked) ? curQ[1] : 1'b0;
    assign bus.errCount = errCountQ;
    assign bus.state    = stateQ;
endmodule

// File: tb/tb_clock_phase_monitor.sv
module tb_clock_phase_monitor;
    logic clk;
    logic rst0;
    logic rst1;

    int checks = 0;
    int errors = 0;

    clock_phase_monitor_if #(.ERR_W(8)) if0 ();
    clock_phase_monitor_if #(.ERR_W(2)) if1 ();

    clock_phase_monitor #(
        .LOCK_CYCLES(4),
        .MAX_MISS   (3),
        .ERR_W      (8)
    ) dut0 (
        .clkIn(clk),
        .reset(rst0),
        .bus  (if0)
    );

    // Narrow saturating counter and a miss limit that isolated errors never hit.
    clock_phase_monitor #(
        .LOCK_CYCLES(4),
        .MAX_MISS   (8),
        .ERR_W      (2)
    ) dut1 (
        .clkIn(clk),
        .reset(rst1),
        .bus  (if1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       rst;
        logic [1:0] ab;
        logic       clr;
        logic [1:0] st;
        logic       lk;
        logic       ft;
        logic       ph;
        logic [7:0] err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk0(input string tag, input logic [1:0] st, input logic lk, input logic ft,
                        input logic ph, input logic [7:0] err);
        chk({tag, " state"}, 32'(if0.state), 32'(st));
        chk({tag, " locked"}, 32'(if0.locked), 32'(lk));
        chk({tag, " fault"}, 32'(if0.fault), 32'(ft));
        chk({tag, " phase"}, 32'(if0.phase), 32'(ph));
        chk({tag, " errCount"}, 32'(if0.errCount), 32'(err));
    endtask

    task automatic step0(input logic r, input logic [1:0] ab, input logic clr);
        rst0           = r;
        if0.phA        = ab[1];
        if0.phB        = ab[0];
        if0.clearFault = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic step1(input logic r, input logic [1:0] ab);
        rst1    = r;
        if1.phA = ab[1];
        if1.phB = ab[0];
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst0 = 1'b1;
        rst1 = 1'b1;
        if0.phA = 1'b0; if0.phB = 1'b0; if0.clearFault = 1'b0;
        if1.phA = 1'b0; if1.phB = 1'b0; if1.clearFault = 1'b0;

        // Expected outputs after the edge on which the inputs are applied.
        //                rst  ab     clr   st    lk    ft    ph    err
        vecs.push_back('{1'b1, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0}); // reset
        vecs.push_back('{1'b1, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0});
        vecs.push_back('{1'b0, 2'b01, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0}); // e1
        vecs.push_back('{1'b0, 2'b10, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 8'd0}); // e2 acquire
        vecs.push_back('{1'b0, 2'b01, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 8'd0}); // e3 first eval
        vecs.push_back('{1'b0, 2'b10, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 8'd0});
        vecs.push_back('{1'b0, 2'b01, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 8'd0});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 2'd2, 1'b1, 1'b0, 1'b1, 8'd0}); // e6 locked
        vecs.push_back('{1'b0, 2'b01, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 8'd0});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 2'd2, 1'b1, 1'b0, 1'b1, 8'd0});
        vecs.push_back('{1'b0, 2'b01, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 8'd0}); // glitch 10,01,11,10
        vecs.push_back('{1'b0, 2'b11, 1'b0, 2'd2, 1'b1, 1'b0, 1'b1, 8'd0});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 2'd2, 1'b1, 1'b0, 1'b1, 8'd1}); // complement bad
        vecs.push_back('{1'b0, 2'b01, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 8'd2}); // toggle bad
        vecs.push_back('{1'b0, 2'b10, 1'b0, 2'd2, 1'b1, 1'b0, 1'b1, 8'd2}); // good, miss clears
        vecs.push_back('{1'b0, 2'b01, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 8'd2});
        vecs.push_back('{1'b0, 2'b11, 1'b0, 2'd2, 1'b1, 1'b0, 1'b1, 8'd2}); // stuck high
        vecs.push_back('{1'b0, 2'b11, 1'b0, 2'd2, 1'b1, 1'b0, 1'b1, 8'd3});
        vecs.push_back('{1'b0, 2'b11, 1'b0, 2'd2, 1'b1, 1'b0, 1'b1, 8'd4});
        vecs.push_back('{1'b0, 2'b11, 1'b0, 2'd3, 1'b0, 1'b1, 1'b0, 8'd5}); // 3rd bad: fault
        vecs.push_back('{1'b0, 2'b11, 1'b0, 2'd3, 1'b0, 1'b1, 1'b0, 8'd5}); // hold
        vecs.push_back('{1'b0, 2'b01, 1'b0, 2'd3, 1'b0, 1'b1, 1'b0, 8'd5});
        vecs.push_back('{1'b0, 2'b10, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 8'd5}); // clearFault
        vecs.push_back('{1'b0, 2'b01, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd5});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 8'd5});
        vecs.push_back('{1'b0, 2'b01, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 8'd5});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 8'd5});
        vecs.push_back('{1'b0, 2'b01, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 8'd5});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 2'd2, 1'b1, 1'b0, 1'b1, 8'd5}); // relocked
        vecs.push_back('{1'b0, 2'b01, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 8'd5}); // clear ignored
        vecs.push_back('{1'b1, 2'b10, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0}); // mid-run reset
        vecs.push_back('{1'b0, 2'b01, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0});

        foreach (vecs[i]) begin
            step0(vecs[i].rst, vecs[i].ab, vecs[i].clr);
            chk0($sformatf("vec%0d", i), vecs[i].st, vecs[i].lk, vecs[i].ft, vecs[i].ph,
                 vecs[i].err);
        end

        // Acquire restart: a repeated sample after 3 good evaluations.
        step0(1'b1, 2'b00, 1'b0);
        chk0("restart reset", 2'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        step0(1'b0, 2'b10, 1'b0);
        step0(1'b0, 2'b01, 1'b0);
        chk0("restart acq", 2'd1, 1'b0, 1'b0, 1'b0, 8'd0);
        step0(1'b0, 2'b10, 1'b0);   // good 1
        step0(1'b0, 2'b01, 1'b0);   // good 2
        step0(1'b0, 2'b01, 1'b0);   // good 3, repeat captured
        step0(1'b0, 2'b10, 1'b0);   // bad: count restarts
        chk0("restart bad", 2'd1, 1'b0, 1'b0, 1'b0, 8'd0);
        step0(1'b0, 2'b01, 1'b0);
        step0(1'b0, 2'b10, 1'b0);
        step0(1'b0, 2'b01, 1'b0);
        chk0("restart 3 good", 2'd1, 1'b0, 1'b0, 1'b0, 8'd0);
        step0(1'b0, 2'b10, 1'b0);
        chk0("restart locked", 2'd2, 1'b1, 1'b0, 1'b1, 8'd0);

        // Saturation on the 2-bit counter, then reset while locked.
        step1(1'b1, 2'b00);
        for (int i = 0; i < 6; i++) begin
            step1(1'b0, (i % 2 == 0) ? 2'b01 : 2'b10);
        end
        chk("sat locked", 32'(if1.locked), 32'd1);
        chk("sat err start", 32'(if1.errCount), 32'd0);
        // Each sample twice in a row, then toggle: one isolated bad every other edge.
        for (int i = 0; i < 10; i++) begin
            int bads;
            step1(1'b0, (((i + 1) / 2) % 2 == 0) ? 2'b10 : 2'b01);
            bads = (i + 1) / 2;
            chk($sformatf("sat err %0d", i), 32'(if1.errCount), (bads > 3) ? 32'd3 : 32'(bads));
            chk($sformatf("sat locked %0d", i), 32'(if1.locked), 32'd1);
        end
        step1(1'b1, 2'b01);
        chk("sat rst state", 32'(if1.state), 32'd0);
        chk("sat rst locked", 32'(if1.locked), 32'd0);
        chk("sat rst fault", 32'(if1.fault), 32'd0);
        chk("sat rst phase", 32'(if1.phase), 32'd0);
        chk("sat rst err", 32'(if1.errCount), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
